// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter that pops bytes from a FIFO read port with a one-cycle strobe
// and sends them back to back while data is available and enable is high.
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned COUNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         fifoData,
    input  logic               fifoEmpty,
    output logic               fifoRe,
    input  logic               enable,
    output logic               tx,
    output logic               busy,
    output logic               frameDone,
    output logic [COUNT_W-1:0] sentCount
);

    localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e             state_q, state_d;
    logic [BaudW-1:0]   baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               fifo_re_q, fifo_re_d;
    logic [COUNT_W-1:0] sent_q, sent_d;

    logic baud_last;
    logic stop_last;
    logic launch;

    assign baud_last = (baud_q == BaudLast);
    assign stop_last = (state_q == StStop) && baud_last;
    // Launch is only sampled in IDLE or the last stop cycle, so the FIFO pop cycle is never seen.
    assign launch    = enable && !fifoEmpty && ((state_q == StIdle) || stop_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (launch) state_d = StStart;
            StStart: if (baud_last) state_d = StData;
            StData:  if (baud_last && (bit_q == 3'd7)) state_d = StStop;
            StStop:  if (stop_last) state_d = launch ? StStart : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        sent_d    = sent_q;
        fifo_re_d = launch;

        if ((state_q == StIdle) || baud_last) begin
            baud_d = '0;
        end else begin
            baud_d = baud_q + BaudW'(1);
        end

        if (launch) begin
            shift_d = fifoData;
            bit_d   = '0;
        end else if ((state_q == StData) && baud_last) begin
            bit_d = bit_q + 3'd1;
        end

        if (stop_last) begin
            sent_d = sent_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            fifo_re_q <= 1'b0;
            sent_q    <= '0;
        end else begin
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            fifo_re_q <= fifo_re_d;
            sent_q    <= sent_d;
        end
    end

    // Line outputs decode the state register so reset drives them without a clock edge.
    always_comb begin
        tx        = 1'b1;
        busy      = 1'b1;
        frameDone = 1'b0;
        unique case (state_q)
            StIdle:  busy = 1'b0;
            StStart: tx = 1'b0;
            StData:  tx = shift_q[bit_q];
            StStop:  frameDone = baud_last;
            default: busy = 1'b0;
        endcase
    end

    assign fifoRe    = fifo_re_q;
    assign sentCount = sent_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: a queue-based FIFO model feeds the DUT and each
// frame is compared against the 8N1 waveform computed from the byte value.
module tb_fifo_uart_tx;

    localparam int Cpb      = 4;
    localparam int FrameLen = 10 * Cpb;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  fifoData;
    logic        fifoEmpty;
    logic        fifoRe;
    logic        enable;
    logic        tx;
    logic        busy;
    logic        frameDone;
    logic [15:0] sentCount;

    int          tests = 0;
    int          fails = 0;
    int          exp_count = 0;
    logic [7:0]  fifo_q[$];
    logic [7:0]  exp_bytes[$];
    logic [7:0]  b0, b1, b2;
    int          nbytes;

    fifo_uart_tx #(
        .CLKS_PER_BIT(Cpb),
        .COUNT_W     (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .fifoData (fifoData),
        .fifoEmpty(fifoEmpty),
        .fifoRe   (fifoRe),
        .enable   (enable),
        .tx       (tx),
        .busy     (busy),
        .frameDone(frameDone),
        .sentCount(sentCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifo();
        if (fifo_q.size() == 0) begin
            fifoEmpty = 1'b1;
            fifoData  = 8'($urandom);
        end else begin
            fifoEmpty = 1'b0;
            fifoData  = fifo_q[0];
        end
    endtask

    // One clock: the FIFO pops on the edge that sees the read strobe.
    task automatic tick();
        logic re_prev;
        re_prev = fifoRe;
        @(posedge clk);
        #1;
        if (re_prev && (fifo_q.size() > 0)) void'(fifo_q.pop_front());
        drive_fifo();
    endtask

    // Called in the first START cycle; checks one whole 8N1 frame of byte b.
    task automatic check_frame(input logic [7:0] b, input int drop_at);
        logic exp_tx;
        int   bitn;
        for (int i = 0; i < FrameLen; i++) begin
            bitn = i / Cpb;
            if (bitn == 0)      exp_tx = 1'b0;
            else if (bitn == 9) exp_tx = 1'b1;
            else                exp_tx = b[bitn-1];
            check($sformatf("tx byte %02h cyc %0d", b, i), tx, exp_tx);
            check($sformatf("busy byte %02h cyc %0d", b, i), busy, 1);
            check($sformatf("fifoRe byte %02h cyc %0d", b, i), fifoRe, i == 0);
            check($sformatf("frameDone byte %02h cyc %0d", b, i), frameDone, i == FrameLen - 1);
            if (i == 0 || i == FrameLen - 1)
                check($sformatf("sentCount byte %02h cyc %0d", b, i), sentCount, exp_count);
            if (i == drop_at) enable = 1'b0;
            tick();
        end
        exp_count++;
    endtask

    task automatic check_idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            check({tag, " tx"}, tx, 1);
            check({tag, " busy"}, busy, 0);
            check({tag, " fifoRe"}, fifoRe, 0);
            check({tag, " frameDone"}, frameDone, 0);
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with a non-empty FIFO and enable high.
        reset  = 1'b1;
        enable = 1'b1;
        fifo_q.push_back(8'h3C);
        drive_fifo();
        #1;
        for (int i = 0; i < 5; i++) begin
            check("reset tx", tx, 1);
            check("reset busy", busy, 0);
            check("reset fifoRe", fifoRe, 0);
            check("reset frameDone", frameDone, 0);
            check("reset sentCount", sentCount, 0);
            tick();
        end
        fifo_q.delete();
        drive_fifo();
        reset = 1'b0;
        check_idle(3, "post-reset idle");

        // Single byte 0xA5; launch sampled at the next edge.
        fifo_q.push_back(8'hA5);
        drive_fifo();
        check("pre-launch busy", busy, 0);
        tick();
        check_frame(8'hA5, -1);
        check_idle(3, "after A5");
        check("single sentCount", sentCount, 1);
        check("single fifo drained", fifo_q.size(), 0);

        // Back to back 0x00 then 0xFF with no idle gap.
        fifo_q.push_back(8'h00);
        fifo_q.push_back(8'hFF);
        drive_fifo();
        tick();
        check_frame(8'h00, -1);
        check_frame(8'hFF, -1);
        check_idle(2, "after b2b");
        check("b2b sentCount", sentCount, 3);

        // Empty FIFO with random data on the bus.
        check_idle(200, "empty");

        // Enable drops during data bit 2 of the first frame.
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        fifo_q.push_back(b0);
        fifo_q.push_back(b1);
        fifo_q.push_back(b2);
        drive_fifo();
        tick();
        check_frame(b0, 4 + 2 * Cpb);
        check_idle(10, "enable low");
        check("gated sentCount", sentCount, 4);
        check("gated fifo depth", fifo_q.size(), 2);
        enable = 1'b1;
        check("re-enable pre-edge busy", busy, 0);
        tick();
        check_frame(b1, -1);
        check_frame(b2, -1);
        check_idle(2, "after gating");

        // Reset during data bit 3; the popped byte is lost.
        fifo_q.push_back(8'($urandom));
        drive_fifo();
        tick();
        for (int i = 0; i < 17; i++) tick();
        check("mid-frame busy", busy, 1);
        #2;
        reset = 1'b1;
        #1;
        check("async reset tx", tx, 1);
        check("async reset busy", busy, 0);
        check("async reset sentCount", sentCount, 0);
        check("popped byte lost", fifo_q.size(), 0);
        b0 = 8'($urandom);
        fifo_q.push_back(b0);
        drive_fifo();
        for (int i = 0; i < 2; i++) begin
            tick();
            check("reset-held fifoRe", fifoRe, 0);
            check("reset-held tx", tx, 1);
        end
        #2;
        reset = 1'b0;
        exp_count = 0;
        tick();
        check_frame(b0, -1);
        check_idle(2, "after reset frame");
        check("restart sentCount", sentCount, 1);

        // Random bursts of random bytes.
        for (int r = 0; r < 4; r++) begin
            nbytes = $urandom_range(1, 3);
            exp_bytes.delete();
            for (int k = 0; k < nbytes; k++) begin
                b0 = 8'($urandom);
                exp_bytes.push_back(b0);
                fifo_q.push_back(b0);
            end
            drive_fifo();
            tick();
            for (int k = 0; k < nbytes; k++) check_frame(exp_bytes[k], -1);
            check_idle($urandom_range(1, 5), "random gap");
            check("random sentCount", sentCount, exp_count);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
